mat_descan: RTL
===============

Name: mat_descan

Overview:
- Inverse zigzag scan for 8x8 blocks. It is the receive-side counterpart of mat_scan.
- Accepts a stream of 64 coefficients per block in zigzag order and emits the same 64 values in raster (row-major) order.
- Sits after entropy decode / before dequant-IDCT. A back-to-back mat_scan -> mat_descan chain is an identity path.
- Ping-pong buffered, so continuous input produces continuous output.

Parameters:
- DW, 10, sample width in bits.

Ports:
- clk  in  1  rising-edge clock, single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- vld_in  in  1  din valid; sampled on rising clk.
- din  in  DW  coefficient, zigzag order.
- vld_out  out  1  dout valid.
- dout  out  DW  coefficient, raster order 0..63.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - vld_out=0, dout=0.
  - Write counter=0, write bank=0, read bank=0, both bank-full flags=0, reader idle.
  - Buffer contents are don't-care.
  - A partially received block is discarded. After release, the next valid sample is zigzag index 0 of a new block.
- Zigzag table ZZ[k] = raster address of zigzag index k, k=0..63:
  - k=0..15: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5
  - k=16..31: 12,19,26,33,40,48,41,34,27,20,13,6,7,14,21,28
  - k=32..47: 35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51
  - k=48..63: 58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63
  - Implemented as a constant 64x6 ROM.
- Storage: two banks of 64 x DW. Storage may be register array or distributed RAM.
- Write side:
  - On each clk edge with vld_in=1: bank[wr_bank][ZZ[wr_cnt]] <= din, and wr_cnt increments (6-bit, wraps 63->0).
  - When wr_cnt==63 is written: full[wr_bank] <= 1 and wr_bank toggles.
  - vld_in=0 holds wr_cnt; gaps of any length are allowed mid-block.
  - No backpressure. Input rate is at most 1 sample/cycle and output drains 64 samples in 64 cycles, so the write bank is always free.
  - A write into a bank whose full flag is set is a protocol violation: behaviour is undefined, no detection required.
- Read side FSM, two states:
  - IDLE: if full[rd_bank]=1, go to OUT, rd_cnt=0.
  - OUT: each cycle dout <= bank[rd_bank][rd_cnt], vld_out <= 1, rd_cnt++.
  - After rd_cnt==63 is issued: clear full[rd_bank] and toggle rd_bank.
  - Then, if full[new rd_bank] is already 1, stay in OUT with rd_cnt=0 (no bubble). Otherwise go to IDLE.
  - In IDLE: vld_out <= 0 and dout holds its last value.
- Latency:
  - Let the 64th sample of a block be sampled at edge E. The first read is issued at edge E+1 and raster[0] appears on dout/vld_out after edge E+1.
  - Raster[r] is valid after edge E+1+r. vld_out stays high for exactly 64 consecutive cycles per block.
  - Outputs are registered; there is no combinational din->dout path.
- Simultaneous events:
  - At the same edge, a write completion may set full[x] while the read finish clears full[y] with x≠y. Both updates take effect.
  - If the write completing into bank x coincides with the reader being in IDLE, the reader does not start until the following edge (the full flag is registered).
  - Continuous input at 1 sample/cycle yields continuous vld_out with no gaps between blocks.
- Values pass through unmodified. No arithmetic; width is DW throughout.

Test Plan:
- Single block: after reset, drive vld_in=1 for 64 cycles with din = ZZ[k] (0,1,8,16,9,2,...,63) -> vld_out high for exactly 64 cycles, starting 1 cycle after the last input edge, with dout=0,1,2,...,63.
- Back-to-back: 128 consecutive samples, block A din=ZZ[k] and block B din=ZZ[k]+100 -> 128 consecutive vld_out cycles: dout 0..63 then 100..163, no bubble.
- Gapped input: same block as the single-block case with vld_in=0 for 3 cycles after every 8th sample -> identical dout 0..63. vld_out rises 1 cycle after the final sample edge, then stays high 64 cycles.
- Reset mid-operation:
  - Assert rst_n=0 after 30 samples of a block -> vld_out=0 and dout=0 immediately (asynchronously).
  - After release, a fresh 64-sample block produces dout 0..63 with no stale data.
- Reset during output: assert rst_n=0 while dout is emitting raster index 20 -> vld_out drops immediately. No further output until a new full block is received.
- Round trip: chain mat_scan -> mat_descan, feed raster 0..63 into mat_scan twice, back-to-back -> mat_descan dout = 0..63 twice; vld_out total count = 128.

Source files
------------

// File: rtl/mat_descan.sv
// rtl/mat_descan.sv - inverse zigzag scan, 8x8 block, ping-pong buffered
module mat_descan #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          vld_in,
    input  logic [DW-1:0] din,
    output logic          vld_out,
    output logic [DW-1:0] dout
);

    typedef enum logic {
        S_IDLE,
        S_OUT
    } state_t;

    // ZZ[k] = raster address of zigzag index k
    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [DW-1:0] mem_q [2][64];

    logic [5:0]    wr_cnt_q, wr_cnt_d;
    logic [5:0]    rd_cnt_q, rd_cnt_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    state_t        state_q, state_d;
    logic          vld_out_q, vld_out_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          rd_issue;

    // Buffer contents need no reset; the full flags gate every read.
    always_ff @(posedge clk) begin
        if (vld_in) begin
            mem_q[wr_bank_q][ZZ[wr_cnt_q]] <= din;
        end
    end

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        state_d   = state_q;
        vld_out_d = 1'b0;
        dout_d    = dout_q;
        rd_issue  = 1'b0;

        case (state_q)
            S_IDLE:  rd_issue = full_q[rd_bank_q];
            S_OUT:   rd_issue = 1'b1;
            default: rd_issue = 1'b0;
        endcase

        // The IDLE->OUT transition issues raster 0 in the same cycle.
        if (rd_issue) begin
            vld_out_d = 1'b1;
            dout_d    = mem_q[rd_bank_q][rd_cnt_q];
            rd_cnt_d  = rd_cnt_q + 6'd1;
            state_d   = S_OUT;
            if (rd_cnt_q == 6'd63) begin
                full_d[rd_bank_q] = 1'b0;
                rd_bank_d         = ~rd_bank_q;
                state_d           = full_q[~rd_bank_q] ? S_OUT : S_IDLE;
            end
        end

        if (vld_in) begin
            wr_cnt_d = wr_cnt_q + 6'd1;
            if (wr_cnt_q == 6'd63) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            state_q   <= S_IDLE;
            vld_out_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            state_q   <= state_d;
            vld_out_q <= vld_out_d;
            dout_q    <= dout_d;
        end
    end

    assign vld_out = vld_out_q;
    assign dout    = dout_q;

endmodule
